// File: rtl/somador_serial_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface somador_serial_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/somador_serial.sv
// Bit-serial adder: s = a + b + cin, one bit per clock, LSB first,
// through a single full-adder cell with a registered carry.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    somador_serial_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic             sum_bit;
    logic             carry_nx;
    logic [WIDTH:0]   rs_ext;
    logic [WIDTH-1:0] rs_shift;

    // Full-adder cell on the current LSBs and the sum register with the new bit entering at the MSB
    always_comb begin
        sum_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
        carry_nx = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
        rs_ext   = {sum_bit, rs_q};
        rs_shift = rs_ext[WIDTH:1];
    end

    // Next-state and datapath update; the result registers load only on the last bit
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    rs_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                rs_d  = rs_shift;
                c_d   = carry_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Counter is wrapped explicitly so non-power-of-two widths stay in range
                    cnt_d   = '0;
                    s_d     = rs_shift;
                    cout_d  = carry_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule
